// File: rtl/hazard_detect_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Pure declarations; nothing here carries timing or flow-control behaviour.
package hazard_pkg;

  localparam int HAZ_REG_AW = 5;
  localparam int X0_IDX     = 0;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hazState_t;

  // True when a multi-cycle issue actually opens a wait window.
  function automatic logic mcOpens(input logic start, input logic luHit,
                                   input logic brTaken, input logic latNz);
    return start && !luHit && !brTaken && latNz;
  endfunction

endpackage

// File: rtl/hazard_detect_unit_if.sv
// Bundle between the ID/EX pipeline glue and the hazard controller.
// Combinational responses on outputs; no handshake, the controller never backpressures.
interface hazard_detect_unit_if import hazard_pkg::*; #(
  parameter int REG_AW      = HAZ_REG_AW,
  parameter int MC_CNT_W    = 6,
  parameter int STALL_CNT_W = 32
) ();

  logic [REG_AW-1:0]      IFID_Rs1_i;
  logic [REG_AW-1:0]      IFID_Rs2_i;
  logic                   IFID_UseRs1_i;
  logic                   IFID_UseRs2_i;
  logic                   IDEX_MemRead_i;
  logic [REG_AW-1:0]      IDEX_Rd_i;
  logic                   MC_Start_i;
  logic [MC_CNT_W-1:0]    MC_Lat_i;
  logic                   Branch_Taken_i;
  logic                   Hazard_o;
  logic                   PCWrite_o;
  logic                   IFIDWrite_o;
  logic                   IFIDFlush_o;
  logic                   Busy_o;
  logic [STALL_CNT_W-1:0] StallCnt_o;

  modport master (
    output IFID_Rs1_i, IFID_Rs2_i, IFID_UseRs1_i, IFID_UseRs2_i,
    output IDEX_MemRead_i, IDEX_Rd_i, MC_Start_i, MC_Lat_i, Branch_Taken_i,
    input  Hazard_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, Busy_o, StallCnt_o
  );

  modport slave (
    input  IFID_Rs1_i, IFID_Rs2_i, IFID_UseRs1_i, IFID_UseRs2_i,
    input  IDEX_MemRead_i, IDEX_Rd_i, MC_Start_i, MC_Lat_i, Branch_Taken_i,
    output Hazard_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, Busy_o, StallCnt_o
  );

endinterface

// File: rtl/hazard_detect_unit_load_use_cmp.sv
// Load-use comparator: flags an ID source register produced by a load now in EX.
// Purely combinational, zero latency; x0 never creates a dependency.
module load_use_cmp import hazard_pkg::*; #(
  parameter int REG_AW = HAZ_REG_AW
) (
  input  logic              memRead,
  input  logic [REG_AW-1:0] exRd,
  input  logic [REG_AW-1:0] idRs1,
  input  logic [REG_AW-1:0] idRs2,
  input  logic              useRs1,
  input  logic              useRs2,
  output logic              luHit
);

  logic rs1Hit;
  logic rs2Hit;
  logic rdLive;

  assign rs1Hit = useRs1 && (idRs1 == exRd);
  assign rs2Hit = useRs2 && (idRs2 == exRd);
  assign rdLive = (exRd != REG_AW'(X0_IDX));
  assign luHit  = memRead && rdLive && (rs1Hit || rs2Hit);

endmodule

// File: rtl/hazard_detect_unit.sv
// Hazard/stall controller: branch flush, load-use bubble, multi-cycle EX wait, stall stats.
// Zero-latency combinational control; multi-cycle ops hold the front end for MC_Lat_i cycles.
module hazard_detect_unit import hazard_pkg::*; #(
  parameter int REG_AW      = HAZ_REG_AW,
  parameter int MC_CNT_W    = 6,
  parameter int STALL_CNT_W = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  hazard_detect_unit_if.slave hz
);

  hazState_t             state;
  hazState_t             stateNxt;
  logic [MC_CNT_W-1:0]   mcCnt;
  logic [MC_CNT_W-1:0]   mcCntNxt;
  logic                  lu;
  logic                  hazard;
  logic                  pcWrite;
  logic                  ifidWrite;
  logic                  ifidFlush;
  logic                  busy;
  logic [STALL_CNT_W-1:0] stallCnt;

  load_use_cmp #(.REG_AW(REG_AW)) u_luCmp (
    .memRead (hz.IDEX_MemRead_i),
    .exRd    (hz.IDEX_Rd_i),
    .idRs1   (hz.IFID_Rs1_i),
    .idRs2   (hz.IFID_Rs2_i),
    .useRs1  (hz.IFID_UseRs1_i),
    .useRs2  (hz.IFID_UseRs2_i),
    .luHit   (lu)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      mcCnt <= '0;
    end else begin
      state <= stateNxt;
      mcCnt <= mcCntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    mcCntNxt = mcCnt;
    if (hz.Branch_Taken_i) begin
      stateNxt = RUN;
      mcCntNxt = '0;
    end else begin
      case (state)
        RUN: begin
          // A load-use stall swallows the issue; ID re-presents the op next cycle.
          if (mcOpens(hz.MC_Start_i, lu, hz.Branch_Taken_i, (hz.MC_Lat_i != '0))) begin
            stateNxt = MC_WAIT;
            mcCntNxt = hz.MC_Lat_i;
          end
        end
        MC_WAIT: begin
          if (mcCnt == MC_CNT_W'(1)) begin
            stateNxt = RUN;
            mcCntNxt = '0;
          end else begin
            mcCntNxt = mcCnt - MC_CNT_W'(1);
          end
        end
        default: begin
          stateNxt = RUN;
          mcCntNxt = '0;
        end
      endcase
    end
  end

  // Reset gates the outputs directly so stray comparator hits cannot leak out.
  always_comb begin
    hazard    = 1'b0;
    pcWrite   = 1'b1;
    ifidWrite = 1'b1;
    ifidFlush = 1'b0;
    busy      = 1'b0;
    if (!rst_i) begin
      busy = (state == MC_WAIT);
      if (hz.Branch_Taken_i) begin
        ifidFlush = 1'b1;
        hazard    = 1'b1;
      end else if (state == MC_WAIT || lu) begin
        hazard    = 1'b1;
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCnt <= '0;
    end else if (!pcWrite && (stallCnt != '1)) begin
      stallCnt <= stallCnt + STALL_CNT_W'(1);
    end
  end

  assign hz.Hazard_o    = hazard;
  assign hz.PCWrite_o   = pcWrite;
  assign hz.IFIDWrite_o = ifidWrite;
  assign hz.IFIDFlush_o = ifidFlush;
  assign hz.Busy_o      = busy;
  assign hz.StallCnt_o  = stallCnt;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scoreboarded bench for hazard_detect_unit: directed scenarios then randomized traffic.
// A second instance with a 4-bit stall counter shares the stimulus to exercise saturation.
module tb_hazard_detect_unit;
  import hazard_pkg::*;

  localparam int AW  = 5;
  localparam int MW  = 6;
  localparam int SW  = 32;
  localparam int SW4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_detect_unit_if #(.REG_AW(AW), .MC_CNT_W(MW), .STALL_CNT_W(SW))  bus ();
  hazard_detect_unit_if #(.REG_AW(AW), .MC_CNT_W(MW), .STALL_CNT_W(SW4)) bus4 ();

  hazard_detect_unit #(.REG_AW(AW), .MC_CNT_W(MW), .STALL_CNT_W(SW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (bus)
  );

  hazard_detect_unit #(.REG_AW(AW), .MC_CNT_W(MW), .STALL_CNT_W(SW4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (bus4)
  );

  assign bus4.IFID_Rs1_i     = bus.IFID_Rs1_i;
  assign bus4.IFID_Rs2_i     = bus.IFID_Rs2_i;
  assign bus4.IFID_UseRs1_i  = bus.IFID_UseRs1_i;
  assign bus4.IFID_UseRs2_i  = bus.IFID_UseRs2_i;
  assign bus4.IDEX_MemRead_i = bus.IDEX_MemRead_i;
  assign bus4.IDEX_Rd_i      = bus.IDEX_Rd_i;
  assign bus4.MC_Start_i     = bus.MC_Start_i;
  assign bus4.MC_Lat_i       = bus.MC_Lat_i;
  assign bus4.Branch_Taken_i = bus.Branch_Taken_i;

  typedef struct {
    logic        hz;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        busy;
    longint      cnt;
    longint      cnt4;
  } exp_t;

  exp_t   expQ[$];
  int     nCmp = 0;
  int     nErr = 0;

  // Reference model: remaining front-end stall cycles and raw stall totals.
  int     waitLeft = 0;
  longint stalls   = 0;
  longint stalls4  = 0;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4  = 15;

  task automatic chk(input string nm, input longint act, input longint req);
    nCmp++;
    if (act != req) begin
      nErr++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("Hazard_o",    longint'(bus.Hazard_o),    longint'(e.hz));
        chk("PCWrite_o",   longint'(bus.PCWrite_o),   longint'(e.pcw));
        chk("IFIDWrite_o", longint'(bus.IFIDWrite_o), longint'(e.ifw));
        chk("IFIDFlush_o", longint'(bus.IFIDFlush_o), longint'(e.fl));
        chk("Busy_o",      longint'(bus.Busy_o),      longint'(e.busy));
        chk("StallCnt_o",  longint'(bus.StallCnt_o),  e.cnt);
        chk("StallCnt4_o", longint'(bus4.StallCnt_o), e.cnt4);
        chk("PCWrite4_o",  longint'(bus4.PCWrite_o),  longint'(e.pcw));
      end
    end
  end

  // Called at posedge+1: apply one cycle of inputs, predict, advance the model.
  task automatic drive(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                       input bit mr, input int rd, input bit mcs, input int lat, input bit br,
                       input bit pulse);
    exp_t e;
    bit   lu;
    rst                = r;
    bus.IFID_Rs1_i     = AW'(rs1);
    bus.IFID_Rs2_i     = AW'(rs2);
    bus.IFID_UseRs1_i  = u1;
    bus.IFID_UseRs2_i  = u2;
    bus.IDEX_MemRead_i = mr;
    bus.IDEX_Rd_i      = AW'(rd);
    bus.MC_Start_i     = mcs;
    bus.MC_Lat_i       = MW'(lat);
    bus.Branch_Taken_i = br;

    lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (r) begin
      e.hz = 0; e.pcw = 1; e.ifw = 1; e.fl = 0; e.busy = 0; e.cnt = 0; e.cnt4 = 0;
    end else begin
      e.busy = (waitLeft > 0);
      e.fl   = br;
      e.cnt  = stalls;
      e.cnt4 = stalls4;
      if (br) begin
        e.hz = 1; e.pcw = 1; e.ifw = 1;
      end else if (waitLeft > 0 || lu) begin
        e.hz = 1; e.pcw = 0; e.ifw = 0;
      end else begin
        e.hz = 0; e.pcw = 1; e.ifw = 1;
      end
    end
    expQ.push_back(e);

    if (pulse) begin
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_Hazard",  longint'(bus.Hazard_o),   0);
      chk("async_PCWrite", longint'(bus.PCWrite_o),  1);
      chk("async_Busy",    longint'(bus.Busy_o),     0);
      chk("async_Cnt",     longint'(bus.StallCnt_o), 0);
      #1 rst = 1'b0;
    end

    @(posedge clk);
    #1;
    if (r || pulse) begin
      waitLeft = 0; stalls = 0; stalls4 = 0;
    end else begin
      if (!e.pcw) begin
        stalls  = (stalls  < MAX32) ? stalls  + 1 : MAX32;
        stalls4 = (stalls4 < MAX4)  ? stalls4 + 1 : MAX4;
      end
      if (br)                                  waitLeft = 0;
      else if (waitLeft > 0)                   waitLeft = waitLeft - 1;
      else if (mcs && !lu && lat != 0)         waitLeft = lat;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic randCycle(input bit r, input bit pulse);
    if (pulse)
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    else
      drive(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            ($urandom_range(0, 4) == 0), $urandom_range(0, 4), ($urandom_range(0, 9) == 0), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.IFID_Rs1_i = '0; bus.IFID_Rs2_i = '0; bus.IFID_UseRs1_i = 0; bus.IFID_UseRs2_i = 0;
    bus.IDEX_MemRead_i = 0; bus.IDEX_Rd_i = '0; bus.MC_Start_i = 0; bus.MC_Lat_i = '0;
    bus.Branch_Taken_i = 0;
    @(posedge clk);
    #1;

    // Reset holds outputs even with a live load-use hit and an MC issue.
    drive(1, 5, 1, 1, 1, 1, 5, 1, 3, 0, 0);
    drive(1, 2, 2, 1, 1, 1, 2, 0, 0, 1, 0);

    // Load x5 then add x6,x5,x1.
    drive(0, 5, 1, 1, 1, 1, 5, 0, 0, 0, 0);
    drive(0, 6, 1, 1, 1, 0, 5, 0, 0, 0, 0);
    // Load to x0 with rs1=x0.
    drive(0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0);
    // rs2 match only.
    drive(0, 1, 7, 1, 1, 1, 7, 0, 0, 0, 0);
    idle();

    // MC latency 3, then spare cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    repeat (4) idle();

    // MC latency 5 with a branch at T+2.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // Load-use and branch together.
    drive(0, 4, 0, 1, 0, 1, 4, 0, 0, 1, 0);
    // Zero-latency MC start, then MC start blocked by load-use.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 3, 0, 1, 0, 1, 3, 1, 4, 0, 0);
    repeat (2) idle();

    // Async reset pulse mid-wait, then a cycle-aligned reset mid-wait.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    repeat (2) idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) idle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) idle();

    // 20 stall cycles from a fresh counter: 4-bit copy pins at 15.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 0);
    repeat (22) idle();

    for (int i = 0; i < 3000; i++) begin
      randCycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 149) == 0));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", longint'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
